// File: rtl/sw_job_sequencer_pkg.sv
// sw_seq_pkg: sequencer states, packed scoring-param layout and accelerator result width.
package sw_seq_pkg;
    localparam int V_E_F_Bit = 16;
    localparam int RESULT_W_DEF = V_E_F_Bit;
    localparam int FIELD_W = 4;
    localparam int MATCH_LSB = 12;
    localparam int MISMATCH_LSB = 8;
    localparam int ALPHA_LSB = 4;
    localparam int BETA_LSB = 0;
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_SETT = 4'd1;
    localparam state_t ST_SETT_GAP = 4'd2;
    localparam state_t ST_SETT_WAIT = 4'd3;
    localparam state_t ST_LOAD = 4'd4;
    localparam state_t ST_START = 4'd5;
    localparam state_t ST_START_GAP = 4'd6;
    localparam state_t ST_WAIT_VALID = 4'd7;
    localparam state_t ST_WAIT_IDLE = 4'd8;
    localparam state_t ST_NEXT = 4'd9;
    localparam state_t ST_DONE = 4'd10;
    localparam state_t ST_TIMEOUT = 4'd11;
    function automatic logic [15:0] pack_param(input logic [FIELD_W-1:0] m, mm, a, b);
        logic [15:0] p;
        p = '0;
        p[MATCH_LSB +: FIELD_W] = m;
        p[MISMATCH_LSB +: FIELD_W] = mm;
        p[ALPHA_LSB +: FIELD_W] = a;
        p[BETA_LSB +: FIELD_W] = b;
        return p;
    endfunction
endpackage

// File: rtl/sw_job_sequencer_if.sv
// sw_job_sequencer_if: control/status bundle between the sequencer and FPGAWrapper.
interface sw_job_sequencer_if import sw_seq_pkg::*; #(
    parameter int PARAM_W = 16,
    parameter int RESULT_W = RESULT_W_DEF
);
    logic                set_t;
    logic                start;
    logic [PARAM_W-1:0]  param;
    logic                busy;
    logic                valid;
    logic [RESULT_W-1:0] result;
    modport master(output set_t, start, param, input busy, valid, result);
    modport slave(input set_t, start, param, output busy, valid, result);
endinterface

// File: rtl/sw_job_sequencer_watchdog.sv
// sw_seq_watchdog: per-state cycle counter that flags a wait lasting TIMEOUT_CYCLES.
module sw_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expired = i_en && r_cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/sw_job_sequencer.sv
// sw_job_sequencer: runs a table of Smith-Waterman parameter sets through the accelerator.
module sw_job_sequencer import sw_seq_pkg::*; #(
    parameter int NUM_JOBS = 4,
    parameter int PARAM_W = 16,
    parameter int RESULT_W = RESULT_W_DEF,
    parameter int TIMEOUT_CYCLES = 500000,
    localparam int AW = NUM_JOBS > 1 ? $clog2(NUM_JOBS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cfg_we,
    input  logic [AW-1:0]       i_cfg_addr,
    input  logic [PARAM_W-1:0]  i_cfg_wdata,
    input  logic                i_go,
    input  logic [AW:0]         i_num_jobs,
    input  logic [AW-1:0]       i_res_addr,
    output logic [RESULT_W-1:0] o_res_data,
    output logic                o_res_ok,
    sw_job_sequencer_if.master  acc,
    output logic                o_running,
    output logic [AW-1:0]       o_job_idx,
    output logic                o_done,
    output logic                o_timeout
);
    state_t              r_state, w_next;
    logic [AW-1:0]       r_job_idx;
    logic [AW:0]         r_num;
    logic [PARAM_W-1:0]  r_params [NUM_JOBS];
    logic [RESULT_W-1:0] r_res [NUM_JOBS];
    logic [NUM_JOBS-1:0] r_ok;
    logic                r_set_t, r_start;
    logic                w_idle, w_wait, w_expired, w_last, w_drive, w_capture;

    assign w_idle = r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_TIMEOUT;
    assign w_wait = r_state == ST_SETT_WAIT || r_state == ST_WAIT_VALID || r_state == ST_WAIT_IDLE;
    assign w_last = (AW+1)'(r_job_idx) + (AW+1)'(1) == r_num;
    assign w_drive = r_state >= ST_LOAD && r_state <= ST_NEXT;
    assign w_capture = r_state == ST_WAIT_VALID && acc.valid;

    sw_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk(clk),
        .rst(rst),
        .i_clr(w_next != r_state),
        .i_en(w_wait),
        .o_expired(w_expired)
    );

    // Progress wins over expiry when both land in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: w_next = i_go ? ST_SETT : r_state;
            ST_SETT:       w_next = ST_SETT_GAP;
            ST_SETT_GAP:   w_next = ST_SETT_WAIT;
            ST_SETT_WAIT:  w_next = !acc.busy ? (r_num == '0 ? ST_DONE : ST_LOAD) : w_expired ? ST_TIMEOUT : r_state;
            ST_LOAD:       w_next = ST_START;
            ST_START:      w_next = ST_START_GAP;
            ST_START_GAP:  w_next = ST_WAIT_VALID;
            ST_WAIT_VALID: w_next = acc.valid ? ST_WAIT_IDLE : w_expired ? ST_TIMEOUT : r_state;
            ST_WAIT_IDLE:  w_next = !acc.busy ? ST_NEXT : w_expired ? ST_TIMEOUT : r_state;
            ST_NEXT:       w_next = w_last ? ST_DONE : ST_LOAD;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_job_idx <= '0;
            r_num <= '0;
            r_ok <= '0;
            r_set_t <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_set_t <= w_next == ST_SETT;
            r_start <= w_next == ST_START;
            if (w_idle && i_go) begin
                r_ok <= '0;
                r_job_idx <= '0;
                r_num <= i_num_jobs > (AW+1)'(NUM_JOBS) ? (AW+1)'(NUM_JOBS) : i_num_jobs;
            end
            if (w_capture) r_ok[r_job_idx] <= 1'b1;
            if (r_state == ST_NEXT && !w_last) r_job_idx <= r_job_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_idle && i_cfg_we) r_params[i_cfg_addr] <= i_cfg_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) r_res <= '{default: '0};
        else if (w_capture) r_res[r_job_idx] <= acc.result;
    end

    assign acc.set_t = r_set_t;
    assign acc.start = r_start;
    assign acc.param = w_drive ? r_params[r_job_idx] : '0;
    assign o_res_data = r_res[i_res_addr];
    assign o_res_ok = r_ok[i_res_addr];
    assign o_running = !w_idle;
    assign o_job_idx = r_job_idx;
    assign o_done = r_state == ST_DONE;
    assign o_timeout = r_state == ST_TIMEOUT;
endmodule

// File: tb/tb_sw_job_sequencer.sv
// tb_sw_job_sequencer: scoreboard bench with a behavioural accelerator model.
module tb_sw_job_sequencer;
    import sw_seq_pkg::*;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cfg_we = 1'b0;
    logic [1:0]  i_cfg_addr = '0;
    logic [15:0] i_cfg_wdata = '0;
    logic        i_go = 1'b0;
    logic [2:0]  i_num_jobs = '0;
    logic [1:0]  i_res_addr = '0;
    logic [15:0] o_res_data;
    logic        o_res_ok, o_running, o_done, o_timeout;
    logic [1:0]  o_job_idx;

    sw_job_sequencer_if #(.PARAM_W(16), .RESULT_W(16)) acc();

    sw_job_sequencer #(.NUM_JOBS(4), .PARAM_W(16), .RESULT_W(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
        .i_go(i_go), .i_num_jobs(i_num_jobs), .i_res_addr(i_res_addr), .o_res_data(o_res_data),
        .o_res_ok(o_res_ok), .acc(acc), .o_running(o_running), .o_job_idx(o_job_idx),
        .o_done(o_done), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0, cyc = 0, n_sett = 0, n_start = 0;
    logic [15:0] q_param[$], q_res[$];
    int st_cyc[$];
    logic [15:0] prev_param = '0;
    logic [15:0] p0, p1;

    function automatic logic [15:0] acc_f(input logic [15:0] p);
        return {p[7:0], p[15:8]} ^ 16'h5A5A;
    endfunction

    // Accelerator model: busy 3 cycles after set_t; after start, busy LAT(+tail) cycles with valid at LAT.
    int s = 0, t = 0, sc = 0, tail = 0;
    bit m_hang = 0, m_double = 0;
    logic [15:0] pres = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            s <= 0; t <= 0; sc <= 0;
        end else begin
            s <= acc.set_t ? 1 : (s != 0 && s < 8) ? s + 1 : 0;
            if (acc.set_t) sc <= 0;
            else if (acc.start) sc <= sc + 1;
            if (acc.start) begin
                t <= 1; pres <= acc_f(acc.param);
            end else t <= (t != 0 && t < LAT + 10) ? t + 1 : 0;
        end
    end
    assign acc.busy = (s >= 1 && s <= 3) || (t >= 1 && t <= LAT + tail);
    assign acc.valid = !(m_hang && sc == 2) && (m_double ? (t == LAT + 1 || t == LAT + 2) : t == LAT);
    assign acc.result = m_double ? (t == LAT + 1 ? 16'd7 : 16'd9) : pres;

    always @(negedge clk) begin
        if (acc.set_t) begin
            n_sett++;
            checks++;
            if (acc.start !== 1'b0) $display("FAIL strobe_overlap start=%b required=0", acc.start);
            else passed++;
        end
        if (acc.start) begin
            n_start++;
            st_cyc.push_back(cyc);
            checks++;
            if (q_param.size() == 0) $display("FAIL unexpected_start param=%h required=no start", acc.param);
            else begin
                logic [15:0] e;
                e = q_param.pop_front();
                if (acc.param !== e || prev_param !== e)
                    $display("FAIL start_param got=%h prev=%h required=%h", acc.param, prev_param, e);
                else passed++;
            end
        end
        prev_param = acc.param;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_sb();
        q_param.delete(); q_res.delete(); st_cyc.delete(); n_sett = 0; n_start = 0;
    endtask

    task automatic load_job(input logic [1:0] a, input logic [15:0] p);
        tick(); i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_wdata = p;
        tick(); i_cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] n);
        tick(); i_go = 1'b1; i_num_jobs = n;
        tick(); i_go = 1'b0;
    endtask

    task automatic wait_end(input string name, output int at);
        at = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_done || o_timeout) begin at = cyc; break; end
        end
        #1;
        checks++;
        if (at < 0) $display("FAIL %s_end done=%b timeout=%b required=end within 400 cycles", name, o_done, o_timeout);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({acc.set_t, acc.start, o_running, o_done, o_timeout} !== 5'b0 || acc.param !== 16'h0 || o_job_idx !== 2'd0)
            $display("FAIL reset_outputs set_t=%b start=%b run=%b done=%b to=%b param=%h idx=%0d required=all 0",
                acc.set_t, acc.start, o_running, o_done, o_timeout, acc.param, o_job_idx);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            i_res_addr = 2'(j); #1;
            checks++;
            if (o_res_ok !== 1'b0 || o_res_data !== 16'h0)
                $display("FAIL reset_res%0d ok=%b data=%h required=0/0000", j, o_res_ok, o_res_data);
            else passed++;
        end
    endtask

    task automatic test_normal();
        int at;
        clear_sb();
        load_job(2'd0, p0); load_job(2'd1, p1);
        q_param.push_back(p0); q_param.push_back(p1);
        q_res.push_back(acc_f(p0)); q_res.push_back(acc_f(p1));
        start_run(3'd2);
        wait_end("normal", at);
        checks++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0 || o_running !== 1'b0)
            $display("FAIL normal_flags done=%b to=%b run=%b required=1/0/0", o_done, o_timeout, o_running);
        else passed++;
        checks++;
        if (n_sett !== 1 || n_start !== 2) $display("FAIL normal_strobes sett=%0d start=%0d required=1/2", n_sett, n_start);
        else passed++;
        checks++;
        if (st_cyc.size() != 2 || st_cyc[1] - st_cyc[0] != 8)
            $display("FAIL normal_gap starts=%0d required=2 starts 8 cycles apart", st_cyc.size());
        else passed++;
        for (int j = 0; j < 2; j++) begin
            logic [15:0] e;
            i_res_addr = 2'(j); #1;
            e = q_res.pop_front();
            checks++;
            if (o_res_data !== e || o_res_ok !== 1'b1)
                $display("FAIL normal_res%0d data=%h ok=%b required=%h/1", j, o_res_data, o_res_ok, e);
            else passed++;
        end
    endtask

    task automatic test_zero_jobs();
        int at;
        clear_sb();
        start_run(3'd0);
        wait_end("zero", at);
        checks++;
        if (o_done !== 1'b1 || n_sett !== 1 || n_start !== 0)
            $display("FAIL zero_run done=%b sett=%0d start=%0d required=1/1/0", o_done, n_sett, n_start);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            i_res_addr = 2'(j); #1;
            checks++;
            if (o_res_ok !== 1'b0) $display("FAIL zero_ok%0d ok=%b required=0", j, o_res_ok);
            else passed++;
        end
    endtask

    task automatic test_hang();
        int at;
        clear_sb();
        m_hang = 1;
        q_param.push_back(p0); q_param.push_back(p1);
        start_run(3'd2);
        wait_end("hang", at);
        checks++;
        if (st_cyc.size() != 2 || at != st_cyc[1] + 66)
            $display("FAIL hang_timing timeout_cycle=%0d starts=%0d required=last start + 66", at, st_cyc.size());
        else passed++;
        checks++;
        if (o_timeout !== 1'b1 || o_done !== 1'b0 || o_running !== 1'b0 || acc.param !== 16'h0)
            $display("FAIL hang_flags to=%b done=%b run=%b param=%h required=1/0/0/0000", o_timeout, o_done, o_running, acc.param);
        else passed++;
        i_res_addr = 2'd0; #1;
        checks++;
        if (o_res_data !== acc_f(p0) || o_res_ok !== 1'b1)
            $display("FAIL hang_res0 data=%h ok=%b required=%h/1", o_res_data, o_res_ok, acc_f(p0));
        else passed++;
        i_res_addr = 2'd1; #1;
        checks++;
        if (o_res_ok !== 1'b0) $display("FAIL hang_ok1 ok=%b required=0", o_res_ok);
        else passed++;
        repeat (20) tick();
        checks++;
        if (n_sett !== 1 || n_start !== 2 || o_timeout !== 1'b1)
            $display("FAIL hang_quiet sett=%0d start=%0d to=%b required=1/2/1", n_sett, n_start, o_timeout);
        else passed++;
        m_hang = 0;
    endtask

    task automatic test_double_valid();
        int at;
        clear_sb();
        m_double = 1;
        q_param.push_back(p0); q_param.push_back(p1);
        start_run(3'd2);
        wait_end("double", at);
        checks++;
        if (st_cyc.size() != 2 || st_cyc[1] - st_cyc[0] != 9 || o_done !== 1'b1)
            $display("FAIL double_advance starts=%0d done=%b required=2 starts 9 cycles apart, done", st_cyc.size(), o_done);
        else passed++;
        for (int j = 0; j < 2; j++) begin
            i_res_addr = 2'(j); #1;
            checks++;
            if (o_res_data !== 16'd7 || o_res_ok !== 1'b1)
                $display("FAIL double_res%0d data=%h ok=%b required=0007/1", j, o_res_data, o_res_ok);
            else passed++;
        end
        m_double = 0;
    endtask

    task automatic test_ignored_controls();
        int at;
        clear_sb();
        q_param.push_back(p0); q_param.push_back(p1);
        q_res.push_back(acc_f(p0)); q_res.push_back(acc_f(p1));
        start_run(3'd2);
        for (int k = 0; k < 50 && n_start == 0; k++) tick();
        i_go = 1'b1; i_num_jobs = 3'd1; i_cfg_we = 1'b1; i_cfg_addr = 2'd1; i_cfg_wdata = 16'hFFFF;
        tick();
        i_go = 1'b0; i_cfg_we = 1'b0;
        wait_end("ignored", at);
        checks++;
        if (o_done !== 1'b1 || n_sett !== 1 || n_start !== 2)
            $display("FAIL ignored_run done=%b sett=%0d start=%0d required=1/1/2", o_done, n_sett, n_start);
        else passed++;
        for (int j = 0; j < 2; j++) begin
            logic [15:0] e;
            i_res_addr = 2'(j); #1;
            e = q_res.pop_front();
            checks++;
            if (o_res_data !== e || o_res_ok !== 1'b1)
                $display("FAIL ignored_res%0d data=%h ok=%b required=%h/1", j, o_res_data, o_res_ok, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        int at;
        clear_sb();
        tail = 3;
        q_param.push_back(p0);
        start_run(3'd2);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc.valid) break;
        end
        tick();
        checks++;
        if (o_running !== 1'b1) $display("FAIL rstmid_running run=%b required=1", o_running);
        else passed++;
        rst = 1'b1;
        tick();
        i_res_addr = 2'd0; #1;
        checks++;
        if ({acc.set_t, acc.start, o_running, o_done, o_timeout, o_res_ok} !== 6'b0 || acc.param !== 16'h0
            || o_job_idx !== 2'd0 || o_res_data !== 16'h0)
            $display("FAIL rstmid_outputs set_t=%b start=%b run=%b done=%b to=%b ok=%b param=%h idx=%0d data=%h required=all 0",
                acc.set_t, acc.start, o_running, o_done, o_timeout, o_res_ok, acc.param, o_job_idx, o_res_data);
        else passed++;
        rst = 1'b0;
        tail = 0;
        clear_sb();
        q_param.push_back(p0); q_param.push_back(p1);
        start_run(3'd2);
        wait_end("rstmid", at);
        checks++;
        if (o_done !== 1'b1 || n_start !== 2) $display("FAIL rstmid_rerun done=%b start=%0d required=1/2", o_done, n_start);
        else passed++;
        i_res_addr = 2'd1; #1;
        checks++;
        if (o_res_data !== acc_f(p1) || o_res_ok !== 1'b1)
            $display("FAIL rstmid_res1 data=%h ok=%b required=%h/1", o_res_data, o_res_ok, acc_f(p1));
        else passed++;
    endtask

    initial begin
        p0 = pack_param(4'd2, 4'd3, 4'd1, 4'd1);
        p1 = pack_param(4'd1, 4'd1, 4'd2, 4'd2);
        test_reset();
        test_normal();
        test_zero_jobs();
        test_hang();
        test_double_valid();
        test_ignored_controls();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit cycles=%0d required=finish earlier", cyc);
        $fatal(1);
    end
endmodule
